mul_share_ctrl: RTL and testbench

- Round-robin controller that shares one sequential signed multiplier core (start pulse, NB-cycle iteration, ready flag) among N requesters.
- Owns the request/response handshakes, operand latching, multiplier start sequencing, product capture and response routing.
- Sits between requesting units and a single multiplier instance, so that multiplier is never driven by more than one client.

---
 rtl/mul_share_ctrl_pkg.sv | 29 ++
 rtl/mul_share_ctrl_if.sv | 40 ++++
 rtl/mul_share_ctrl_rr_arbiter.sv | 33 +++
 rtl/mul_share_ctrl.sv | 126 ++++++++++++
 tb/tb_mul_share_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_share_ctrl_pkg.sv
// Shared definitions for the multiplier-sharing controller: FSM state
// encoding, the core's ready-bit index and the operand-width check.
package mul_pkg;

   // Controller phases: arbitrate, pulse start, wait for core, hold result
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // Default operand width and the bit of the core's iteration counter
   // that acts as its ready flag.
   localparam int NB_DEF    = 32;
   localparam int READY_BIT = $clog2(NB_DEF);

   // The core's ready flag only lines up with NB iterations when NB is a
   // power of two of at least 4.
   function automatic bit nb_is_valid(input int nb);
      return (nb >= 4) && ((nb & (nb - 1)) == 0);
   endfunction

   // Ready-bit index for an arbitrary operand width.
   function automatic int ready_bit(input int nb);
      return $clog2(nb);
   endfunction

endpackage

// File: rtl/mul_share_ctrl_if.sv
// Bundle of requester-side and core-side signals around the controller.
//
// Handshake rules: a request transfers on a clock edge where req_valid[i]
// and req_ready[i] are both high; req_ready is combinational and at most
// one bit is high. A response transfers on an edge where resp_valid and
// resp_ready are both high; resp_valid, resp_id and resp_product are held
// stable until that edge and resp_valid never drops without a transfer
// (except on reset). mul_start is a single-cycle pulse; mul_a/mul_b are
// stable while the core iterates and mul_ready is sampled only after start.
interface mul_share_ctrl_if #(
   parameter int N   = 4,
   parameter int NB  = 32,
   parameter int IDW = $clog2(N)
);
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*NB-1:0] req_a;
   logic [N*NB-1:0] req_b;
   logic            resp_valid;
   logic [IDW-1:0]  resp_id;
   logic [2*NB-1:0] resp_product;
   logic            resp_ready;
   logic            mul_start;
   logic [NB-1:0]   mul_a;
   logic [NB-1:0]   mul_b;
   logic [2*NB-1:0] mul_product;
   logic            mul_ready;

   // Controller side
   modport slave (
      input  req_valid, req_a, req_b, resp_ready, mul_product, mul_ready,
      output req_ready, resp_valid, resp_id, resp_product, mul_start, mul_a, mul_b
   );

   // Environment side: requesters plus the multiplier core
   modport master (
      output req_valid, req_a, req_b, resp_ready, mul_product, mul_ready,
      input  req_ready, resp_valid, resp_id, resp_product, mul_start, mul_a, mul_b
   );
endinterface

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// searching upward from the pointer, wrapping at N.
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   i_req,
   input  logic [IDW-1:0] i_ptr,
   input  logic           i_en,
   output logic [N-1:0]   o_grant,
   output logic [IDW-1:0] o_id
);

   logic [IDW-1:0] w_idx;
   logic           w_found;

   // Scan from the pointer with wrap and take the first asserted request
   always_comb begin
      o_grant = '0;
      o_id    = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 0; k < N; k++) begin
         w_idx = IDW'((int'(i_ptr) + k) % N);
         if (i_en && !w_found && i_req[w_idx]) begin
            w_found        = 1'b1;
            o_grant[w_idx] = 1'b1;
            o_id           = w_idx;
         end
      end
   end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one sequential signed multiplier core among N requesters. One
// operation is in flight at a time; requesters are served round-robin.
module mul_share_ctrl
   import mul_pkg::*;
#(
   parameter int NB  = 32,
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   mul_share_ctrl_if.slave bus,
   output state_t          o_dbg_state
);

   if (!nb_is_valid(NB)) begin : g_bad_nb
      $error("mul_share_ctrl: NB must be a power of two >= 4");
   end
   if (N < 2 || N > 8) begin : g_bad_n
      $error("mul_share_ctrl: N must be in 2..8");
   end

   state_t          r_state;
   state_t          w_state_nxt;
   logic [IDW-1:0]  r_rr_ptr;
   logic [IDW-1:0]  r_grant_id;
   logic [IDW-1:0]  w_grant_id;
   logic [IDW-1:0]  w_ptr_nxt;
   logic [N-1:0]    w_grant;
   logic            w_arb_en;
   logic            w_grant_any;
   logic [NB-1:0]   r_mul_a;
   logic [NB-1:0]   r_mul_b;
   logic [NB-1:0]   w_sel_a;
   logic [NB-1:0]   w_sel_b;
   logic            r_resp_valid;
   logic [IDW-1:0]  r_resp_id;
   logic [2*NB-1:0] r_resp_product;

   // Arbitration is only live in IDLE and is held off while reset is active
   assign w_arb_en = rst_n && (r_state == ST_IDLE);

   rr_arbiter #(
      .N   (N),
      .IDW (IDW)
   ) u_arb (
      .i_req   (bus.req_valid),
      .i_ptr   (r_rr_ptr),
      .i_en    (w_arb_en),
      .o_grant (w_grant),
      .o_id    (w_grant_id)
   );

   assign w_grant_any = |w_grant;

   // Pointer advances to the requester just after the one served
   assign w_ptr_nxt = (r_grant_id == IDW'(N - 1)) ? '0 : r_grant_id + 1'b1;

   // Select the granted requester's operand slices
   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      for (int i = 0; i < N; i++) begin
         if (w_grant[i]) begin
            w_sel_a = bus.req_a[i*NB +: NB];
            w_sel_b = bus.req_b[i*NB +: NB];
         end
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_grant_any)    w_state_nxt = ST_ISSUE;
         ST_ISSUE:                     w_state_nxt = ST_WAIT;
         ST_WAIT:  if (bus.mul_ready)  w_state_nxt = ST_RESP;
         ST_RESP:  if (bus.resp_ready) w_state_nxt = ST_IDLE;
         default:                      w_state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Operand latch on accept, product capture on core done, pointer update on response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr       <= '0;
         r_grant_id     <= '0;
         r_mul_a        <= '0;
         r_mul_b        <= '0;
         r_resp_valid   <= 1'b0;
         r_resp_id      <= '0;
         r_resp_product <= '0;
      end else begin
         if (r_state == ST_IDLE && w_grant_any) begin
            r_mul_a    <= w_sel_a;
            r_mul_b    <= w_sel_b;
            r_grant_id <= w_grant_id;
         end
         if (r_state == ST_WAIT && bus.mul_ready) begin
            r_resp_valid   <= 1'b1;
            r_resp_id      <= r_grant_id;
            r_resp_product <= bus.mul_product;
         end
         if (r_state == ST_RESP && bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_rr_ptr     <= w_ptr_nxt;
         end
      end
   end

   assign bus.req_ready    = w_grant;
   assign bus.mul_start    = (r_state == ST_ISSUE);
   assign bus.mul_a        = r_mul_a;
   assign bus.mul_b        = r_mul_b;
   assign bus.resp_valid   = r_resp_valid;
   assign bus.resp_id      = r_resp_id;
   assign bus.resp_product = r_resp_product;
   assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl with a behavioural multiplier core, a
// timeline-based reference model and a per-cycle compare process.
module tb_mul_share_ctrl;
   import mul_pkg::*;

   localparam int NB   = 32;
   localparam int N    = 4;
   localparam int IDW  = 2;
   localparam int MAXO = 128;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   mul_share_ctrl_if #(.N(N), .NB(NB), .IDW(IDW)) bus ();
   state_t dbg_state;

   mul_share_ctrl #(.NB(NB), .N(N), .IDW(IDW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ---------------- check bookkeeping ----------------
   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] x, y;
      x = $signed(a);
      y = $signed(b);
      return x * y;
   endfunction

   function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
      int j;
      for (int k = 0; k < N; k++) begin
         j = (ptr + k) % N;
         if (v[j[1:0]]) return j;
      end
      return -1;
   endfunction

   // ---------------- multiplier core (no reset) ----------------
   logic [READY_BIT:0] core_cnt;
   logic [2*NB-1:0]    core_p;
   always @(posedge clk) begin
      if (bus.mul_start) begin
         core_cnt <= '0;
         core_p   <= smul(bus.mul_a, bus.mul_b);
      end else if (!core_cnt[READY_BIT]) begin
         core_cnt <= core_cnt + 1'b1;
      end
   end
   assign bus.mul_ready   = core_cnt[READY_BIT];
   assign bus.mul_product = core_cnt[READY_BIT] ? core_p : ~core_p;

   // ---------------- requester driver ----------------
   logic [31:0]  op_a [N][MAXO];
   logic [31:0]  op_b [N][MAXO];
   int           head [N];
   int           tail [N];
   logic [N-1:0] acc_seen = '0;
   bit           rand_rr  = 1'b0;
   logic         rr_hold  = 1'b1;

   task automatic enqueue(input int i, input logic [31:0] a, input logic [31:0] b);
      if (tail[i] < MAXO) begin
         op_a[i][tail[i]] = a;
         op_b[i][tail[i]] = b;
         tail[i]++;
      end
   endtask

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc_seen[i]) head[i]++;
         if (head[i] < tail[i]) begin
            bus.req_valid[i]       = 1'b1;
            bus.req_a[i*NB +: NB]  = op_a[i][head[i]];
            bus.req_b[i*NB +: NB]  = op_b[i][head[i]];
         end else begin
            bus.req_valid[i]       = 1'b0;
            bus.req_a[i*NB +: NB]  = '0;
            bus.req_b[i*NB +: NB]  = '0;
         end
      end
      bus.resp_ready = rand_rr ? ($urandom_range(0, 3) != 0) : rr_hold;
   end

   // ---------------- reference model ----------------
   // Timeline view: an accepted op issues on the next cycle, its result is
   // visible NB+2 edges after acceptance and stays until consumed.
   bit          m_busy = 1'b0;
   int          m_age  = 0;
   int          m_gid  = 0;
   int          m_ptr  = 0;
   logic [31:0] m_a    = '0;
   logic [31:0] m_b    = '0;
   logic [63:0] exp_q[$];
   int          id_q[$];

   always @(posedge clk) begin : model
      int g;
      if (!rst_n) begin
         m_busy = 1'b0;
         m_ptr  = 0;
         m_a    = '0;
         m_b    = '0;
         exp_q.delete();
         id_q.delete();
      end else if (!m_busy) begin
         g = rr_pick(m_ptr, bus.req_valid);
         if (g >= 0) begin
            m_busy = 1'b1;
            m_age  = 0;
            m_gid  = g;
            m_a    = bus.req_a[g*NB +: NB];
            m_b    = bus.req_b[g*NB +: NB];
            exp_q.push_back(smul(m_a, m_b));
            id_q.push_back(g);
         end
      end else if (m_age >= NB + 2) begin
         if (bus.resp_ready) begin
            m_busy = 1'b0;
            m_ptr  = (m_gid + 1) % N;
            void'(exp_q.pop_front());
            void'(id_q.pop_front());
         end
      end else begin
         m_age++;
      end
   end

   // ---------------- compare process ----------------
   logic [IDW-1:0] obs_id[$];
   logic [63:0]    obs_p[$];

   always @(negedge clk) begin : cmp
      logic [N-1:0] exp_rr;
      int           g;
      bit           exp_rv;
      acc_seen = bus.req_ready;
      if (!rst_n) begin
         check("rst_req_ready", bus.req_ready, 0);
         check("rst_resp_valid", bus.resp_valid, 0);
         check("rst_resp_id", bus.resp_id, 0);
         check("rst_resp_product", bus.resp_product, 0);
         check("rst_mul_start", bus.mul_start, 0);
         check("rst_mul_a", bus.mul_a, 0);
         check("rst_mul_b", bus.mul_b, 0);
      end else begin
         exp_rr = '0;
         if (!m_busy) begin
            g = rr_pick(m_ptr, bus.req_valid);
            if (g >= 0) exp_rr = 4'b0001 << g;
         end
         check("req_ready", bus.req_ready, exp_rr);
         check("mul_start", bus.mul_start, (m_busy && m_age == 0));
         if (m_busy && m_age <= NB + 1) begin
            check("mul_a", bus.mul_a, m_a);
            check("mul_b", bus.mul_b, m_b);
         end
         exp_rv = m_busy && (m_age >= NB + 2);
         check("resp_valid", bus.resp_valid, exp_rv);
         if (exp_rv && exp_q.size() > 0) begin
            check("resp_id", bus.resp_id, id_q[0]);
            check("resp_product", bus.resp_product, exp_q[0]);
         end
         if (bus.resp_valid && bus.resp_ready) begin
            obs_id.push_back(bus.resp_id);
            obs_p.push_back(bus.resp_product);
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_obs(input int n, input int budget);
      int c = 0;
      while (obs_p.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      check($sformatf("resp_count_%0d", n), (obs_p.size() >= n), 1);
   endtask

   task automatic check_obs(input int k, input int id, input logic [63:0] p);
      if (obs_p.size() > k) begin
         check($sformatf("obs%0d_id", k), obs_id[k], id);
         check($sformatf("obs%0d_product", k), obs_p[k], p);
      end else begin
         check($sformatf("obs%0d_present", k), obs_p.size(), k + 1);
      end
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (n) @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'h7FFF_FFFF;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h0000_0000;
         default: return $urandom();
      endcase
   endfunction

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got=timeout expected=done");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin : main
      int t0;
      int c;
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", dbg_state, ST_IDLE);
      check("reset_resp_valid", bus.resp_valid, 0);
      check("reset_mul_start", bus.mul_start, 0);
      rst_n = 1'b1;

      // Single op with latency measurement
      enqueue(0, 32'd3, 32'd5);
      c = 0;
      while (!bus.req_ready[0] && c < 50) begin
         @(negedge clk);
         c++;
      end
      check("single_accept", bus.req_ready, 4'b0001);
      t0 = cyc;
      c  = 0;
      while (!bus.resp_valid && c < 100) begin
         @(negedge clk);
         c++;
      end
      check("single_latency", cyc - t0 - 1, 34);
      wait_obs(1, 50);
      check_obs(0, 0, 64'd15);

      // Signed operands on requester 2
      enqueue(2, -32'sd3, 32'sd7);
      wait_obs(2, 100);
      check_obs(1, 2, 64'hFFFF_FFFF_FFFF_FFEB);
      enqueue(2, -32'sd4, -32'sd6);
      wait_obs(3, 100);
      check_obs(2, 2, 64'd24);

      // Pointer now past requester 2: requester 3 wins over 0
      enqueue(0, 32'd11, 32'd2);
      enqueue(3, -32'sd5, 32'sd9);
      wait_obs(5, 200);
      check_obs(3, 3, 64'hFFFF_FFFF_FFFF_FFD3);
      check_obs(4, 0, 64'd22);

      // Reset ten cycles into the wait phase aborts the operation
      enqueue(0, 32'd100, 32'd100);
      c = 0;
      while (!bus.mul_start && c < 50) begin
         @(negedge clk);
         c++;
      end
      check("abort_issue_seen", bus.mul_start, 1);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("abort_resp_valid", bus.resp_valid, 0);
      check("abort_mul_start", bus.mul_start, 0);
      check("abort_mul_a", bus.mul_a, 0);
      check("abort_state", dbg_state, ST_IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      enqueue(1, 32'd6, 32'd7);
      wait_obs(6, 100);
      check_obs(5, 1, 64'd42);

      // Round robin with all four requesting
      do_reset(2);
      for (int i = 0; i < N; i++) enqueue(i, 32'(i + 1), 32'd10);
      enqueue(0, 32'd1, 32'd10);
      wait_obs(11, 400);
      check_obs(6, 0, 64'd10);
      check_obs(7, 1, 64'd20);
      check_obs(8, 2, 64'd30);
      check_obs(9, 3, 64'd40);
      check_obs(10, 0, 64'd10);

      // Backpressure: result held for 20 cycles, nothing else moves
      rr_hold = 1'b0;
      enqueue(1, 32'd9, -32'sd2);
      enqueue(2, 32'd5, 32'd5);
      c = 0;
      while (!bus.resp_valid && c < 100) begin
         @(negedge clk);
         c++;
      end
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("bp_resp_valid", bus.resp_valid, 1);
         check("bp_resp_id", bus.resp_id, 1);
         check("bp_resp_product", bus.resp_product, 64'hFFFF_FFFF_FFFF_FFEE);
         check("bp_req_ready", bus.req_ready, 0);
         check("bp_mul_start", bus.mul_start, 0);
      end
      rr_hold = 1'b1;
      wait_obs(13, 200);
      check_obs(11, 1, 64'hFFFF_FFFF_FFFF_FFEE);
      check_obs(12, 2, 64'd25);

      // Random traffic with random response backpressure
      rand_rr = 1'b1;
      for (int k = 0; k < 40; k++) enqueue($urandom_range(0, N - 1), rnd_op(), rnd_op());
      wait_obs(53, 5000);
      rand_rr = 1'b0;
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
